// File: rtl/riscv_defines.sv
// Shared fetch-path types: word width, prefetch FSM states
// and the {addr, instr} FIFO entry layout.
package riscv_defines;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID,
    WAIT_ABORTED
  } pf_state_e;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with synchronous flush.
// Ports: push/wdata in, pop/rdata (head) out, count of entries.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/prefetch_buffer.sv
// Sequential instruction prefetcher: one outstanding imem
// req/gnt/rvalid transaction, results buffered in fetch_fifo.
module prefetch_buffer
  import riscv_defines::*;
#(
  parameter int                    DEPTH     = 2,
  parameter logic [WORD_WIDTH-1:0] BOOT_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  branch_i,
  input  logic [WORD_WIDTH-1:0] branch_addr_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [WORD_WIDTH-1:0] rdata_o,
  output logic [WORD_WIDTH-1:0] addr_o,
  output logic                  busy_o,
  output logic                  imem_req_o,
  output logic [WORD_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [WORD_WIDTH-1:0] imem_rdata_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  pf_state_e state;
  pf_state_e state_nxt;

  logic [WORD_WIDTH-1:0] fetch_addr;
  logic [WORD_WIDTH-1:0] inflight_addr;
  logic [WORD_WIDTH-1:0] target;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occ;
  logic                  run;
  logic                  push;
  logic                  pop;
  logic                  credit;
  logic                  issue;
  logic                  unused_lsb;
  fetch_entry_t          head;
  fetch_entry_t          wentry;

  assign target     = {branch_addr_i[WORD_WIDTH-1:2], 2'b00};
  assign unused_lsb = ^branch_addr_i[1:0];

  assign valid_o = (fifo_count != '0);
  assign pop     = valid_o && ready_i && !branch_i;
  assign push    = (state == WAIT_RVALID)
                && imem_rvalid_i && !branch_i;

  // Occupancy after this cycle's push/pop; a new request
  // may only claim a slot that will still be free.
  assign occ = {1'b0, fifo_count}
             + {{CW{1'b0}}, push}
             - {{CW{1'b0}}, pop};
  assign credit = (occ < DEPTH_C);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        issue = req_i && credit;
      end
      WAIT_GNT: begin
        issue = 1'b1;
      end
      WAIT_RVALID, WAIT_ABORTED: begin
        issue = imem_rvalid_i && !branch_i
             && req_i && credit;
      end
      default: begin
        issue = 1'b0;
      end
    endcase
    // run gates requests off while reset is held
    issue = issue && run;

    unique case (state)
      IDLE, WAIT_GNT: begin
        if (issue && imem_gnt_i) begin
          state_nxt = branch_i ? WAIT_ABORTED
                               : WAIT_RVALID;
        end else if (issue && !branch_i) begin
          state_nxt = WAIT_GNT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT_RVALID, WAIT_ABORTED: begin
        if (!imem_rvalid_i) begin
          state_nxt = branch_i ? WAIT_ABORTED : state;
        end else if (issue) begin
          state_nxt = imem_gnt_i ? WAIT_RVALID
                                 : WAIT_GNT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // fetch_addr is the next address to request; the
  // granted one moves to inflight_addr for the push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run           <= 1'b0;
      fetch_addr    <= BOOT_ADDR;
      inflight_addr <= '0;
    end else begin
      run <= 1'b1;
      if (issue && imem_gnt_i) begin
        inflight_addr <= fetch_addr;
        fetch_addr    <= fetch_addr + WORD_WIDTH'(4);
      end
      if (branch_i) begin
        fetch_addr <= target;
      end
    end
  end

  assign wentry.addr  = inflight_addr;
  assign wentry.instr = imem_rdata_i;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*WORD_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (branch_i),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count)
  );

  assign rdata_o     = head.instr;
  assign addr_o      = head.addr;
  assign imem_req_o  = issue;
  assign imem_addr_o = fetch_addr;
  assign busy_o      = (state != IDLE) || valid_o;

endmodule
